roulette_round_ctrl: RTL and testbench

Round sequencer for the roulette table. It buffers up to MAX_BETS latched bets from the keyboard bet decoder and, on a spin request, runs the wheel motor for a fixed time. It then waits for the wheel-result number from the sensor side and replays every stored bet, paired with that number, to the payout logic over a valid/ready handshake. It sits between the keyboard/bet-decode path and the payout/regfile path, and replaces ad-hoc per-bet latch registers with a single sequenced round.

---
 rtl/roulette_pkg.sv | 35 +++
 rtl/roulette_round_ctrl_bet_store.sv | 27 ++
 rtl/roulette_round_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_roulette_round_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/roulette_pkg.sv
// Shared types and constants for the roulette round sequencer: round states,
// bus widths, the legal pocket range and the bet byte layout {color, opcode}.
package roulette_pkg;

   localparam int BET_W      = 8;
   localparam int NUM_W      = 6;
   localparam int MAX_POCKET = 36;

   localparam int COLOR_HI  = 7;
   localparam int COLOR_LO  = 6;
   localparam int OPCODE_HI = 5;
   localparam int OPCODE_LO = 0;

   typedef enum logic [2:0] {
      ST_BET,
      ST_SPIN,
      ST_WAIT_RESULT,
      ST_PAYOUT,
      ST_DONE
   } round_state_t;

   typedef struct packed {
      logic [COLOR_HI-COLOR_LO:0]   color;
      logic [OPCODE_HI-OPCODE_LO:0] opcode;
   } bet_t;

   function automatic logic [COLOR_HI-COLOR_LO:0] bet_color(input logic [BET_W-1:0] b);
      return b[COLOR_HI:COLOR_LO];
   endfunction

   function automatic logic [OPCODE_HI-OPCODE_LO:0] bet_opcode(input logic [BET_W-1:0] b);
      return b[OPCODE_HI:OPCODE_LO];
   endfunction

endpackage

// File: rtl/roulette_round_ctrl_bet_store.sv
// Bet buffer for one round: DEPTH x BET_W register array with a synchronous
// write port and a combinational read port (reads past DEPTH return zero).
module bet_store
   import roulette_pkg::*;
#(
   parameter int DEPTH = 12,
   parameter int AW    = 4
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [BET_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [BET_W-1:0] rdata
);

   logic [BET_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/roulette_round_ctrl.sv
// Roulette round sequencer: collect bets, spin, wait for the wheel result, replay bets to payout.
// Optional macro BET_UNDO_EN adds a bet_undo input that removes the most recent bet while betting.
module roulette_round_ctrl
   import roulette_pkg::*;
#(
   parameter int MAX_BETS       = 12,
   parameter int SPIN_CYCLES    = 100_000_000,
   parameter int RESULT_TIMEOUT = 500_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bet_valid,
   input  logic [BET_W-1:0] bet_data,
   output logic             bet_ready,
   input  logic             spin_req,
   output logic             motor_en,
   input  logic             result_valid,
   input  logic [NUM_W-1:0] result_num,
   output logic             pay_valid,
   output logic [BET_W-1:0] pay_bet,
   output logic [NUM_W-1:0] pay_num,
   input  logic             pay_ready,
`ifdef BET_UNDO_EN
   input  logic             bet_undo,
`endif
   output logic [3:0]       bet_count,
   output logic             round_done,
   output logic             result_err
);

   localparam int AW      = (MAX_BETS > 1) ? $clog2(MAX_BETS) : 1;
   localparam int CNT_MAX = (SPIN_CYCLES > RESULT_TIMEOUT) ? SPIN_CYCLES : RESULT_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   round_state_t     state_reg, state_next;
   logic [3:0]       bet_count_reg, bet_count_next;
   logic [3:0]       idx_reg, idx_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             motor_en_reg, motor_en_next;
   logic             pay_valid_reg, pay_valid_next;
   logic [NUM_W-1:0] pay_num_reg, pay_num_next;
   logic             round_done_reg, round_done_next;
   logic             result_err_reg, result_err_next;

   logic             undo_hit;
   logic             bet_accept;
   logic [3:0]       count_after_bet;
   logic             pay_fire;
   logic             last_item;
   logic             spin_over;
   logic             wait_over;
   logic             result_ok;
   logic [BET_W-1:0] store_rdata;

`ifdef BET_UNDO_EN
   assign undo_hit = (state_reg == ST_BET) && bet_undo && (bet_count_reg != 4'd0);
`else
   assign undo_hit = 1'b0;
`endif

   // An effective undo blocks acceptance so the buffer tail is never both removed and rewritten.
   assign bet_ready  = (state_reg == ST_BET) && (bet_count_reg < 4'(MAX_BETS)) && !undo_hit;
   assign bet_accept = bet_valid && bet_ready;

   assign count_after_bet = undo_hit   ? (bet_count_reg - 4'd1) :
                            bet_accept ? (bet_count_reg + 4'd1) : bet_count_reg;

   assign pay_fire  = pay_valid_reg && pay_ready;
   assign last_item = pay_fire && (idx_reg == (bet_count_reg - 4'd1));
   assign spin_over = (cnt_reg == CNT_W'(SPIN_CYCLES - 1));
   assign wait_over = (cnt_reg == CNT_W'(RESULT_TIMEOUT - 1));
   assign result_ok = (result_num <= NUM_W'(MAX_POCKET));

   bet_store #(
      .DEPTH (MAX_BETS),
      .AW    (AW)
   ) u_store (
      .clock (clock),
      .we    (bet_accept),
      .waddr (bet_count_reg[AW-1:0]),
      .wdata (bet_data),
      .raddr (idx_reg[AW-1:0]),
      .rdata (store_rdata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_BET;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_BET: begin
            // A bet accepted together with spin_req is part of this round.
            if (spin_req && (count_after_bet != 4'd0)) state_next = ST_SPIN;
         end
         ST_SPIN: begin
            if (spin_over) state_next = ST_WAIT_RESULT;
         end
         ST_WAIT_RESULT: begin
            if (result_valid)   state_next = result_ok ? ST_PAYOUT : ST_DONE;
            else if (wait_over) state_next = ST_DONE;
         end
         ST_PAYOUT: begin
            if (last_item) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_BET;
         default: state_next = ST_BET;
      endcase
   end

   always_comb begin
      bet_count_next  = bet_count_reg;
      idx_next        = idx_reg;
      pay_num_next    = pay_num_reg;
      result_err_next = result_err_reg;

      if (state_next != state_reg) begin
         cnt_next = '0;
      end else if ((state_reg == ST_SPIN) || (state_reg == ST_WAIT_RESULT)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end else begin
         cnt_next = cnt_reg;
      end

      unique case (state_reg)
         ST_BET: begin
            bet_count_next = count_after_bet;
            if (state_next == ST_SPIN) result_err_next = 1'b0;
         end
         ST_WAIT_RESULT: begin
            if (result_valid) begin
               if (result_ok) pay_num_next    = result_num;
               else           result_err_next = 1'b1;
            end else if (wait_over) begin
               result_err_next = 1'b1;
            end
         end
         ST_PAYOUT: begin
            if (pay_fire) idx_next = idx_reg + 4'd1;
         end
         ST_DONE: begin
            bet_count_next = 4'd0;
            idx_next       = 4'd0;
         end
         default: ;
      endcase

      // Registered outputs are loaded from the upcoming state so they line up with it.
      motor_en_next   = (state_next == ST_SPIN);
      pay_valid_next  = (state_next == ST_PAYOUT);
      round_done_next = (state_next == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bet_count_reg  <= 4'd0;
         idx_reg        <= 4'd0;
         cnt_reg        <= '0;
         motor_en_reg   <= 1'b0;
         pay_valid_reg  <= 1'b0;
         pay_num_reg    <= '0;
         round_done_reg <= 1'b0;
         result_err_reg <= 1'b0;
      end else begin
         bet_count_reg  <= bet_count_next;
         idx_reg        <= idx_next;
         cnt_reg        <= cnt_next;
         motor_en_reg   <= motor_en_next;
         pay_valid_reg  <= pay_valid_next;
         pay_num_reg    <= pay_num_next;
         round_done_reg <= round_done_next;
         result_err_reg <= result_err_next;
      end
   end

   assign bet_count  = bet_count_reg;
   assign motor_en   = motor_en_reg;
   assign pay_valid  = pay_valid_reg;
   assign pay_bet    = pay_valid_reg ? store_rdata : '0;
   assign pay_num    = pay_num_reg;
   assign round_done = round_done_reg;
   assign result_err = result_err_reg;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// Bench for roulette_round_ctrl: queue-based round model checked every cycle plus directed
// literal checks. Define BET_UNDO_EN to also exercise the undo port.
module tb_roulette_round_ctrl;

   localparam int MAXB = 12;
   localparam int SPIN = 4;
   localparam int TOUT = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic       bet_valid;
   logic [7:0] bet_data;
   logic       bet_ready;
   logic       spin_req;
   logic       motor_en;
   logic       result_valid;
   logic [5:0] result_num;
   logic       pay_valid;
   logic [7:0] pay_bet;
   logic [5:0] pay_num;
   logic       pay_ready;
`ifdef BET_UNDO_EN
   logic       bet_undo;
`endif
   logic [3:0] bet_count;
   logic       round_done;
   logic       result_err;

   roulette_round_ctrl #(
      .MAX_BETS       (MAXB),
      .SPIN_CYCLES    (SPIN),
      .RESULT_TIMEOUT (TOUT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .bet_valid    (bet_valid),
      .bet_data     (bet_data),
      .bet_ready    (bet_ready),
      .spin_req     (spin_req),
      .motor_en     (motor_en),
      .result_valid (result_valid),
      .result_num   (result_num),
      .pay_valid    (pay_valid),
      .pay_bet      (pay_bet),
      .pay_num      (pay_num),
      .pay_ready    (pay_ready),
`ifdef BET_UNDO_EN
      .bet_undo     (bet_undo),
`endif
      .bet_count    (bet_count),
      .round_done   (round_done),
      .result_err   (result_err)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Round model: stored bets as a queue, spin/wait as countdowns.
   typedef enum {M_BET, M_SPIN, M_WAIT, M_PAY, M_DONE} mphase_t;
   mphase_t    m_phase = M_BET;
   logic [7:0] m_bets[$];
   int         m_left = 0;
   int         m_k = 0;
   logic [5:0] m_num = 6'd0;
   logic       m_err = 1'b0;
   logic       m_acc;

   function automatic logic m_undo_now();
`ifdef BET_UNDO_EN
      return (m_phase == M_BET) && bet_undo && (m_bets.size() > 0);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_phase = M_BET;
         m_bets.delete();
         m_k   = 0;
         m_num = 6'd0;
         m_err = 1'b0;
      end else begin
         case (m_phase)
            M_BET: begin
               m_acc = bet_valid && (m_bets.size() < MAXB) && !m_undo_now();
               if (m_undo_now()) void'(m_bets.pop_back());
               else if (m_acc)   m_bets.push_back(bet_data);
               if (spin_req && m_bets.size() > 0) begin
                  m_phase = M_SPIN;
                  m_left  = SPIN;
                  m_err   = 1'b0;
               end
            end
            M_SPIN: begin
               m_left--;
               if (m_left == 0) begin
                  m_phase = M_WAIT;
                  m_left  = TOUT;
               end
            end
            M_WAIT: begin
               if (result_valid) begin
                  if (result_num <= 6'd36) begin
                     m_num   = result_num;
                     m_k     = 0;
                     m_phase = M_PAY;
                  end else begin
                     m_err   = 1'b1;
                     m_phase = M_DONE;
                  end
               end else begin
                  m_left--;
                  if (m_left == 0) begin
                     m_err   = 1'b1;
                     m_phase = M_DONE;
                  end
               end
            end
            M_PAY: begin
               if (pay_ready) begin
                  m_k++;
                  if (m_k == m_bets.size()) m_phase = M_DONE;
               end
            end
            M_DONE: begin
               m_bets.delete();
               m_k     = 0;
               m_phase = M_BET;
            end
            default: m_phase = M_BET;
         endcase
      end
   end

   typedef struct {
      logic [7:0] b;
      logic [5:0] n;
      int         c;
   } item_t;
   item_t pay_log[$];
   int    motor_total = 0;
   int    done_total  = 0;
   int    cyc = 0;

   // Per-cycle comparison against the model, plus activity counters for the directed checks.
   always @(negedge clock) begin
      cyc++;
      check("cyc_bet_ready", 32'(bet_ready),
            32'((m_phase == M_BET) && (m_bets.size() < MAXB) && !m_undo_now()));
      check("cyc_bet_count", 32'(bet_count), 32'(m_bets.size()));
      check("cyc_motor_en", 32'(motor_en), 32'(m_phase == M_SPIN));
      check("cyc_pay_valid", 32'(pay_valid), 32'(m_phase == M_PAY));
      if (m_phase == M_PAY) check("cyc_pay_bet", 32'(pay_bet), 32'(m_bets[m_k]));
      check("cyc_pay_num", 32'(pay_num), 32'(m_num));
      check("cyc_round_done", 32'(round_done), 32'(m_phase == M_DONE));
      check("cyc_result_err", 32'(result_err), 32'(m_err));
      if (motor_en === 1'b1) motor_total++;
      if (round_done === 1'b1) done_total++;
      if (pay_valid === 1'b1 && pay_ready === 1'b1) pay_log.push_back('{pay_bet, pay_num, cyc});
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic offer_bet(input logic [7:0] b);
      bet_valid = 1'b1;
      bet_data  = b;
      tick();
      bet_valid = 1'b0;
   endtask

   task automatic do_spin();
      spin_req = 1'b1;
      tick();
      spin_req = 1'b0;
   endtask

   task automatic give_result(input logic [5:0] n);
      result_valid = 1'b1;
      result_num   = n;
      tick();
      result_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (round_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("round_done_within_budget", 32'(seen), 32'd1);
   endtask

   int m0, d0, l0;

   initial begin
      reset = 1'b1; bet_valid = 1'b0; bet_data = 8'h00; spin_req = 1'b0;
      result_valid = 1'b0; result_num = 6'd0; pay_ready = 1'b1;
`ifdef BET_UNDO_EN
      bet_undo = 1'b0;
`endif
      repeat (2) tick();
      reset = 1'b0;
      check("rst_bet_count", 32'(bet_count), 32'd0);
      check("rst_bet_ready", 32'(bet_ready), 32'd1);
      check("rst_motor_en", 32'(motor_en), 32'd0);
      check("rst_pay_valid", 32'(pay_valid), 32'd0);
      check("rst_pay_bet", 32'(pay_bet), 32'd0);
      check("rst_pay_num", 32'(pay_num), 32'd0);
      check("rst_round_done", 32'(round_done), 32'd0);
      check("rst_result_err", 32'(result_err), 32'd0);

      // Basic round: three bets, result 17.
      m0 = motor_total; d0 = done_total; l0 = pay_log.size();
      offer_bet(8'h45); offer_bet(8'h8A); offer_bet(8'h41);
      check("t1_count3", 32'(bet_count), 32'd3);
      do_spin();
      check("t1_motor_on", 32'(motor_en), 32'd1);
      repeat (5) tick();
      give_result(6'd17);
      check("t1_first_pay_valid", 32'(pay_valid), 32'd1);
      wait_done(20);
      tick();
      check("t1_motor_cycles", 32'(motor_total - m0), 32'd4);
      check("t1_done_pulses", 32'(done_total - d0), 32'd1);
      check("t1_items", 32'(pay_log.size() - l0), 32'd3);
      if (pay_log.size() - l0 == 3) begin
         check("t1_item0", {18'd0, pay_log[l0].b, pay_log[l0].n}, {18'd0, 8'h45, 6'd17});
         check("t1_item1", {18'd0, pay_log[l0+1].b, pay_log[l0+1].n}, {18'd0, 8'h8A, 6'd17});
         check("t1_item2", {18'd0, pay_log[l0+2].b, pay_log[l0+2].n}, {18'd0, 8'h41, 6'd17});
         check("t1_consecutive", 32'(pay_log[l0+2].c - pay_log[l0].c), 32'd2);
      end
      check("t1_count_clear", 32'(bet_count), 32'd0);

      // Buffer full: 13 offered, 12 stored.
      l0 = pay_log.size();
      for (int i = 0; i < 13; i++) offer_bet(8'(8'h10 + i));
      check("t2_count12", 32'(bet_count), 32'd12);
      check("t2_ready_low", 32'(bet_ready), 32'd0);
      do_spin();
      repeat (5) tick();
      give_result(6'd5);
      wait_done(40);
      tick();
      check("t2_items", 32'(pay_log.size() - l0), 32'd12);
      if (pay_log.size() - l0 == 12) begin
         check("t2_first", 32'(pay_log[l0].b), 32'h10);
         check("t2_last", 32'(pay_log[l0+11].b), 32'h1B);
      end

      // Spin with no bets ignored; spin together with the first bet starts a round.
      m0 = motor_total; l0 = pay_log.size();
      do_spin();
      repeat (2) tick();
      check("t3_no_motor", 32'(motor_total - m0), 32'd0);
      bet_valid = 1'b1; bet_data = 8'h22; spin_req = 1'b1;
      tick();
      bet_valid = 1'b0; spin_req = 1'b0;
      check("t3_motor_on", 32'(motor_en), 32'd1);
      repeat (5) tick();
      give_result(6'd0);
      wait_done(20);
      tick();
      check("t3_items", 32'(pay_log.size() - l0), 32'd1);
      if (pay_log.size() - l0 == 1)
         check("t3_item", {18'd0, pay_log[l0].b, pay_log[l0].n}, {18'd0, 8'h22, 6'd0});

      // Timeout, then illegal pocket.
      l0 = pay_log.size(); d0 = done_total;
      offer_bet(8'h05);
      do_spin();
      wait_done(30);
      check("t4_timeout_err", 32'(result_err), 32'd1);
      tick();
      offer_bet(8'h06);
      do_spin();
      check("t4_err_cleared", 32'(result_err), 32'd0);
      repeat (5) tick();
      give_result(6'd40);
      check("t4_illegal_err", 32'(result_err), 32'd1);
      check("t4_illegal_done", 32'(round_done), 32'd1);
      tick();
      check("t4_no_items", 32'(pay_log.size() - l0), 32'd0);
      check("t4_done_pulses", 32'(done_total - d0), 32'd2);

      // Payout stall with pay_ready 1,0,0,1.
      l0 = pay_log.size();
      offer_bet(8'h11); offer_bet(8'h22);
      do_spin();
      repeat (5) tick();
      give_result(6'd9);
      tick();
      pay_ready = 1'b0;
      check("t5_stall_bet_a", 32'(pay_bet), 32'h22);
      tick();
      check("t5_stall_bet_b", 32'(pay_bet), 32'h22);
      check("t5_stall_valid", 32'(pay_valid), 32'd1);
      tick();
      pay_ready = 1'b1;
      check("t5_stall_bet_c", 32'(pay_bet), 32'h22);
      tick();
      check("t5_done", 32'(round_done), 32'd1);
      tick();
      check("t5_items", 32'(pay_log.size() - l0), 32'd2);
      if (pay_log.size() - l0 == 2)
         check("t5_gap", 32'(pay_log[l0+1].c - pay_log[l0].c), 32'd3);

      // Reset during SPIN aborts the round silently.
      d0 = done_total; l0 = pay_log.size();
      offer_bet(8'h33);
      do_spin();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_motor_off", 32'(motor_en), 32'd0);
      check("t6_count_zero", 32'(bet_count), 32'd0);
      repeat (20) tick();
      check("t6_no_done", 32'(done_total - d0), 32'd0);
      check("t6_no_items", 32'(pay_log.size() - l0), 32'd0);

`ifdef BET_UNDO_EN
      l0 = pay_log.size();
      offer_bet(8'h31); offer_bet(8'h32);
      bet_undo = 1'b1;
      tick();
      bet_undo = 1'b0;
      check("t7_undo_count", 32'(bet_count), 32'd1);
      do_spin();
      repeat (5) tick();
      give_result(6'd3);
      wait_done(20);
      tick();
      check("t7_items", 32'(pay_log.size() - l0), 32'd1);
      if (pay_log.size() - l0 == 1) check("t7_item", 32'(pay_log[l0].b), 32'h31);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
